// File: rtl/mic_sample_arbiter_pkg.sv
// Shared types and default sizes for the microphone sample arbiter.
package mic_arb_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 18;
  localparam int CNT_W_DEF  = 8;
  localparam int CH_W_DEF   = $clog2(N_CH_DEF);

  typedef logic [DATA_W_DEF-1:0] sample_t;
  typedef logic [CH_W_DEF-1:0]   ch_id_t;

endpackage

// File: rtl/mic_sample_arbiter_rr.sv
// Combinational round-robin picker: first requesting channel after last_grant, wrapping.
module rr_arbiter
  import mic_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pend,
  input  logic [CH_W-1:0] last_grant,
  output logic            grant_valid,
  output logic [CH_W-1:0] grant_id
);

  // Distance of channel c from the slot just after lg, in round-robin order.
  function automatic int rr_dist(input int c, input int lg);
    return (c - lg - 1 + 2 * N_CH) % N_CH;
  endfunction

  int best;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    best        = N_CH;
    for (int c = 0; c < N_CH; c++) begin
      if (pend[c] && (rr_dist(c, int'(last_grant)) < best)) begin
        best        = rr_dist(c, int'(last_grant));
        grant_valid = 1'b1;
        grant_id    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/mic_sample_arbiter.sv
// Captures per-channel mic samples and serialises them round-robin onto one valid/ready port.
// Define MIC_ARB_OVR_CNT_EN to build saturating per-channel overrun counters on ovr_cnt.
module mic_sample_arbiter
  import mic_arb_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_rdy,
  input  logic [N_CH-1:0]        ch_en,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH-1:0]        overrun,
  input  logic                   clear_overrun,
  output logic [N_CH*CNT_W-1:0]  ovr_cnt
);

  logic [DATA_W-1:0] hold [N_CH];
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   cap;
  logic [N_CH-1:0]   drain;
  logic [N_CH-1:0]   ovr_evt;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_id;
  logic              grant_valid;
  logic              load;

  assign load = !out_valid || out_ready;
  assign cap  = ch_rdy & ch_en;
  // A channel disabled this cycle is never granted; its stale sample is dropped.
  assign req  = pend & ch_en;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr (
    .pend        (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    drain = '0;
    for (int c = 0; c < N_CH; c++) begin
      drain[c] = load && grant_valid && (grant_id == CH_W'(c));
    end
  end

  // A capture that lands on a drained slot is a clean hand-over, not an overrun.
  assign ovr_evt = cap & pend & ~drain;

  // Capture stage -> output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= '0;
      last_grant <= CH_W'(N_CH - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      overrun    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        hold[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cap[c]) begin
          hold[c] <= ch_data[c*DATA_W +: DATA_W];
        end
        if (!ch_en[c]) begin
          pend[c] <= 1'b0;
        end else if (cap[c]) begin
          pend[c] <= 1'b1;
        end else if (drain[c]) begin
          pend[c] <= 1'b0;
        end
      end

      if (load) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_data   <= hold[grant_id];
          out_ch     <= grant_id;
          last_grant <= grant_id;
        end
      end

      overrun <= clear_overrun ? ovr_evt : (overrun | ovr_evt);
    end
  end

`ifdef MIC_ARB_OVR_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt [N_CH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ovr_evt[c]) begin
          cnt[c] <= clear_overrun ? CNT_W'(1) : sat_inc(cnt[c]);
        end else if (clear_overrun) begin
          cnt[c] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign ovr_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_mic_sample_arbiter.sv
// Directed bench for mic_sample_arbiter: capture, round-robin, stall, overrun, enable, reset.
module tb_mic_sample_arbiter;

  localparam int N_CH   = 4;
  localparam int DATA_W = 18;
  localparam int CNT_W  = 2;
  localparam int CH_W   = 2;
`ifdef MIC_ARB_OVR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_rdy;
  logic [N_CH-1:0]        ch_en;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_CH-1:0]        overrun;
  logic                   clear_overrun;
  logic [N_CH*CNT_W-1:0]  ovr_cnt;

  int checks = 0;
  int errors = 0;

  mic_sample_arbiter #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ch_data       (ch_data),
    .ch_rdy        (ch_rdy),
    .ch_en         (ch_en),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .ovr_cnt       (ovr_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
    ch_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ch_data = '0; ch_rdy = '0; ch_en = 4'hF;
    out_ready = 1'b1; clear_overrun = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Single sample on ch2: visible two edges after the strobe
    set_data(2, 18'h2A5A5); ch_rdy = 4'b0100;
    tick(); ch_rdy = '0;
    check("t1_valid_t1", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h2A5A5);
    check("t1_ch", 32'(out_ch), 32'd2);
    check("t1_overrun", 32'(overrun), 32'd0);
    tick();
    check("t1_idle", 32'(out_valid), 32'd0);

    // Round-robin from a fresh reset, two bursts
    reset = 1'b1; tick(); reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_CH; i++) set_data(i, 18'(32'h100 * (r + 1) + i));
      ch_rdy = 4'hF;
      tick(); ch_rdy = '0;
      for (int i = 0; i < N_CH; i++) begin
        tick();
        check($sformatf("t2_valid_r%0d_%0d", r, i), 32'(out_valid), 32'd1);
        check($sformatf("t2_ch_r%0d_%0d", r, i), 32'(out_ch), 32'(i));
        check($sformatf("t2_data_r%0d_%0d", r, i), 32'(out_data), 32'h100 * (r + 1) + i);
      end
      tick();
      check($sformatf("t2_idle_r%0d", r), 32'(out_valid), 32'd0);
    end

    // Backpressure with ch1 pending, two more ch1 strobes while stalled
    out_ready = 1'b0;
    set_data(1, 18'h1A1A1); ch_rdy = 4'b0010;
    tick(); ch_rdy = '0;
    tick();
    check("t3_first", 32'(out_data), 32'h1A1A1);
    for (int k = 0; k < 10; k++) begin
      ch_rdy = (k == 2 || k == 5) ? 4'b0010 : 4'b0000;
      set_data(1, (k == 2) ? 18'h0B1B1 : 18'h0C1C1);
      tick();
      check($sformatf("t3_stall_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("t3_stall_data_%0d", k), 32'(out_data), 32'h1A1A1);
      check($sformatf("t3_stall_ch_%0d", k), 32'(out_ch), 32'd1);
    end
    ch_rdy = '0;
    check("t3_overrun", 32'(overrun), 32'b0010);
    out_ready = 1'b1;
    tick();
    check("t3_last_data", 32'(out_data), 32'h0C1C1);
    check("t3_last_ch", 32'(out_ch), 32'd1);
    tick();
    check("t3_idle", 32'(out_valid), 32'd0);
    check("t3_sticky", 32'(overrun), 32'b0010);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    check("t3_cleared", 32'(overrun), 32'd0);

    // Same-cycle capture and drain on ch3
    set_data(3, 18'h3D0D0); ch_rdy = 4'b1000;
    tick();
    set_data(3, 18'h3D1D1);
    tick(); ch_rdy = '0;
    check("t4_old_data", 32'(out_data), 32'h3D0D0);
    check("t4_old_ch", 32'(out_ch), 32'd3);
    tick();
    check("t4_new_data", 32'(out_data), 32'h3D1D1);
    check("t4_new_valid", 32'(out_valid), 32'd1);
    check("t4_overrun", 32'(overrun), 32'd0);
    tick();
    check("t4_idle", 32'(out_valid), 32'd0);

    // Disabled ch0 strobing produces nothing
    ch_en = 4'b1110;
    for (int k = 0; k < 7; k++) begin
      set_data(0, 18'(k + 5));
      ch_rdy = (k < 5) ? 4'b0001 : 4'b0000;
      tick();
      check($sformatf("t5_dis_%0d", k), 32'(out_valid), 32'd0);
    end
    ch_rdy = '0; ch_en = 4'hF;

    // Reset mid-stream with a stalled output and fresh overruns
    out_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) set_data(i, 18'(32'h300 + i));
    ch_rdy = 4'hF;
    tick(); ch_rdy = '0;
    tick();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_ch", 32'(out_ch), 32'd0);
    ch_rdy = 4'hF;
    tick(); ch_rdy = '0;
    check("t5_pre_overrun", 32'(overrun), 32'b1110);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", 32'(out_data), 32'd0);
    check("t5_rst_ch", 32'(out_ch), 32'd0);
    check("t5_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("t5_dropped", 32'(out_valid), 32'd0);

    // Repeated overruns on ch1, then clear, then clear racing a new overrun
    out_ready = 1'b0;
    set_data(1, 18'h15555); ch_rdy = 4'b0010;
    for (int k = 0; k < 7; k++) tick();
    ch_rdy = '0;
    check("t6_overrun", 32'(overrun), 32'b0010);
    check("t6_cnt_sat", 32'(ovr_cnt[1*CNT_W +: CNT_W]), CNT_EN ? 32'd3 : 32'd0);
    check("t6_cnt_ch0", 32'(ovr_cnt[0 +: CNT_W]), 32'd0);
    clear_overrun = 1'b1;
    tick();
    check("t6_clr_flag", 32'(overrun), 32'd0);
    check("t6_clr_cnt", 32'(ovr_cnt), 32'd0);
    ch_rdy = 4'b0010;
    tick(); ch_rdy = '0; clear_overrun = 1'b0;
    check("t6_race_flag", 32'(overrun), 32'b0010);
    check("t6_race_cnt", 32'(ovr_cnt[1*CNT_W +: CNT_W]), CNT_EN ? 32'd1 : 32'd0);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    check("t6_final_flag", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    check("t6_drain_ch", 32'(out_ch), 32'd1);
    check("t6_drain_data", 32'(out_data), 32'h15555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
